// File: rtl/cpu_pkg.sv
// Shared definitions for the RAM arbiter: state encoding, port identifiers
// and default bus widths.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } arb_state_t;

  localparam logic CPU_PORT = 1'b0;
  localparam logic LDR_PORT = 1'b1;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int CNT_W  = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, and a tie goes
// to the port that did not win last time.
module rr_arb2
  import cpu_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_gnt,
  output logic grant,
  output logic valid
);

  always_comb begin
    valid = req0 | req1;
    grant = CPU_PORT;
    if (req0 && req1) begin
      grant = ~last_gnt;
    end else if (req1) begin
      grant = LDR_PORT;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one RAM port between the CPU controller (port 0) and the loader/DMA
// (port 1). One access in flight, fixed-length strobe window, one-cycle ack.
module mem_bus_arbiter
  import cpu_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int WAIT_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_ena,
  output logic          mem_read,
  output logic          mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_id,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake: a requester raises reqN with weN/addrN/wdataN stable and keeps
  // them until ackN. Fields are sampled only on the grant edge; ackN is a single
  // cycle pulse, and reqN still high in the cycle after ackN is a new request.

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYC - 1);

  arb_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             last_gnt;
  logic             gnt_q;
  logic             we_q;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic             arb_grant;
  logic             arb_valid;

  rr_arb2 u_arb (
    .req0     (req0),
    .req1     (req1),
    .last_gnt (last_gnt),
    .grant    (arb_grant),
    .valid    (arb_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (arb_valid) state_nxt = ST_ACCESS;
      ST_ACCESS: if (cnt == '0) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // last_gnt resets to the loader so the CPU wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      last_gnt <= LDR_PORT;
      gnt_q    <= CPU_PORT;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid) begin
            gnt_q   <= arb_grant;
            we_q    <= arb_grant ? we1 : we0;
            addr_q  <= arb_grant ? addr1 : addr0;
            wdata_q <= arb_grant ? wdata1 : wdata0;
            cnt     <= CNT_INIT;
          end
        end
        ST_ACCESS: begin
          if (cnt == '0) begin
            if (!we_q) begin
              if (gnt_q) rdata1 <= mem_rdata;
              else       rdata0 <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: last_gnt <= gnt_q;
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state flop so reset drops them at once.
  assign mem_ena   = (state == ST_ACCESS);
  assign mem_read  = mem_ena & ~we_q;
  assign mem_write = mem_ena & we_q;
  assign mem_addr  = mem_ena ? addr_q : '0;
  assign mem_wdata = mem_ena ? wdata_q : '0;
  assign ack0      = (state == ST_DONE) & ~gnt_q;
  assign ack1      = (state == ST_DONE) & gnt_q;
  assign busy      = (state != ST_IDLE);
  assign gnt_id    = gnt_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: three builds (WAIT_CYC 2, 1, 15) driven by directed
// scenarios and random traffic, checked every cycle against a transaction model.
module tb_mem_bus_arbiter;
  import cpu_pkg::*;

  localparam int NI = 3;

  function automatic int wc_of(input int g);
    case (g)
      0:       return 2;
      1:       return 1;
      default: return 15;
    endcase
  endfunction

  function automatic logic [7:0] fill_val(input int i, input int a);
    if (a == 16) return 8'h5A;
    return 8'((a * 7 + i * 13 + 3) & 255);
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  initial forever #5 clk = ~clk;

  logic       req0_v[NI], we0_v[NI], req1_v[NI], we1_v[NI];
  logic [7:0] addr0_v[NI], wdata0_v[NI], addr1_v[NI], wdata1_v[NI];
  logic       ack0_v[NI], ack1_v[NI], mem_ena_v[NI], mem_read_v[NI], mem_write_v[NI];
  logic       busy_v[NI], gnt_v[NI];
  logic [7:0] rdata0_v[NI], rdata1_v[NI], mem_addr_v[NI], mem_wdata_v[NI], mem_rdata_v[NI];
  logic [1:0] dbg_v[NI];
  logic [7:0] ram[NI][256];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mem_bus_arbiter #(.AW(8), .DW(8), .WAIT_CYC(wc_of(g))) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req0      (req0_v[g]),
      .we0       (we0_v[g]),
      .addr0     (addr0_v[g]),
      .wdata0    (wdata0_v[g]),
      .ack0      (ack0_v[g]),
      .rdata0    (rdata0_v[g]),
      .req1      (req1_v[g]),
      .we1       (we1_v[g]),
      .addr1     (addr1_v[g]),
      .wdata1    (wdata1_v[g]),
      .ack1      (ack1_v[g]),
      .rdata1    (rdata1_v[g]),
      .mem_ena   (mem_ena_v[g]),
      .mem_read  (mem_read_v[g]),
      .mem_write (mem_write_v[g]),
      .mem_addr  (mem_addr_v[g]),
      .mem_wdata (mem_wdata_v[g]),
      .mem_rdata (mem_rdata_v[g]),
      .gnt_id    (gnt_v[g]),
      .busy      (busy_v[g]),
      .dbg_state (dbg_v[g])
    );
    assign mem_rdata_v[g] = ram[g][mem_addr_v[g]];
  end

  // RAM attached to each build.
  initial begin
    for (int i = 0; i < NI; i++)
      for (int a = 0; a < 256; a++) ram[i][a] = fill_val(i, a);
    forever begin
      @(posedge clk);
      for (int i = 0; i < NI; i++)
        if (mem_write_v[i]) ram[i][mem_addr_v[i]] <= mem_wdata_v[i];
    end
  end

  // ---------------- transaction model ----------------
  // Each grant is an edge number; everything else is an offset from it:
  // strobes for offsets 0..W-1, ack at W, next grant no earlier than W+2.
  int         edge_n;
  int         g_edge[NI];
  bit         g_port[NI], g_we[NI], last_m[NI];
  logic [7:0] g_addr[NI], g_wdata[NI];
  logic [7:0] exp_rd[NI][2];
  logic [7:0] mmem[NI][256];

  initial begin
    edge_n = 0;
    for (int i = 0; i < NI; i++) begin
      g_edge[i] = -1000; last_m[i] = 1'b1; g_port[i] = 1'b0; g_we[i] = 1'b0;
      g_addr[i] = 8'h00; g_wdata[i] = 8'h00; exp_rd[i][0] = 8'h00; exp_rd[i][1] = 8'h00;
      for (int a = 0; a < 256; a++) mmem[i][a] = fill_val(i, a);
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < NI; i++) begin
          g_edge[i] = -1000; last_m[i] = 1'b1; exp_rd[i][0] = 8'h00; exp_rd[i][1] = 8'h00;
        end
      end else begin
        edge_n++;
        for (int i = 0; i < NI; i++) begin
          int w;
          bit win;
          w = wc_of(i);
          if (edge_n == g_edge[i] + w) begin
            if (g_we[i]) mmem[i][g_addr[i]] = g_wdata[i];
            else         exp_rd[i][g_port[i]] = mmem[i][g_addr[i]];
          end
          if (edge_n >= g_edge[i] + w + 2 && (req0_v[i] || req1_v[i])) begin
            win        = (req0_v[i] && req1_v[i]) ? !last_m[i] : req1_v[i];
            g_edge[i]  = edge_n;
            g_port[i]  = win;
            g_we[i]    = win ? we1_v[i] : we0_v[i];
            g_addr[i]  = win ? addr1_v[i] : addr0_v[i];
            g_wdata[i] = win ? wdata1_v[i] : wdata0_v[i];
            last_m[i]  = win;
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int         total = 0, bad = 0, tick_n = 0;
  int         rd_cnt[NI], wr_cnt[NI], busy_cnt[NI], ack_n[NI];
  int         ack_at[NI][8];
  bit         ack_port[NI][8];
  logic [7:0] wr_addr_seen[NI], wr_data_seen[NI];
  int         rem[NI][2];

  task automatic chk(input string nm, input int inst, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      if (bad <= 40)
        $display("FAIL %s inst=%0d got=%0h exp=%0h at %0t", nm, inst, got, exp, $time);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NI; i++) begin
      rd_cnt[i] = 0; wr_cnt[i] = 0; busy_cnt[i] = 0; ack_n[i] = 0;
      wr_addr_seen[i] = 8'h00; wr_data_seen[i] = 8'h00;
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      int w, d;
      bit s, ak, bz;
      w  = wc_of(i);
      d  = edge_n - g_edge[i];
      s  = (d >= 0) && (d < w);
      ak = (d == w);
      bz = (d >= 0) && (d <= w);
      chk("mem_ena",   i, int'(mem_ena_v[i]),   int'(s));
      chk("mem_read",  i, int'(mem_read_v[i]),  int'(s && !g_we[i]));
      chk("mem_write", i, int'(mem_write_v[i]), int'(s && g_we[i]));
      chk("ack0",      i, int'(ack0_v[i]),      int'(ak && !g_port[i]));
      chk("ack1",      i, int'(ack1_v[i]),      int'(ak && g_port[i]));
      chk("busy",      i, int'(busy_v[i]),      int'(bz));
      chk("rdata0",    i, int'(rdata0_v[i]),    int'(exp_rd[i][0]));
      chk("rdata1",    i, int'(rdata1_v[i]),    int'(exp_rd[i][1]));
      if (bz) chk("gnt_id", i, int'(gnt_v[i]), int'(g_port[i]));
      if (s) chk("mem_addr", i, int'(mem_addr_v[i]), int'(g_addr[i]));
      if (s && g_we[i]) chk("mem_wdata", i, int'(mem_wdata_v[i]), int'(g_wdata[i]));
      if (mem_read_v[i]) rd_cnt[i]++;
      if (mem_write_v[i]) begin
        wr_cnt[i]++; wr_addr_seen[i] = mem_addr_v[i]; wr_data_seen[i] = mem_wdata_v[i];
      end
      if (busy_v[i]) busy_cnt[i]++;
      if (ack0_v[i] || ack1_v[i]) begin
        if (ack_n[i] < 8) begin
          ack_at[i][ack_n[i]] = tick_n; ack_port[i][ack_n[i]] = ack1_v[i];
        end
        ack_n[i]++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    tick_n++;
  endtask

  task automatic new_req(input int i, input int p, input bit we, input logic [7:0] a,
                         input logic [7:0] dt, input int n);
    if (p == 0) begin
      req0_v[i] = 1'b1; we0_v[i] = we; addr0_v[i] = a; wdata0_v[i] = dt;
    end else begin
      req1_v[i] = 1'b1; we1_v[i] = we; addr1_v[i] = a; wdata1_v[i] = dt;
    end
    rem[i][p] = n;
  endtask

  task automatic drop_req(input int i, input int p);
    if (p == 0) req0_v[i] = 1'b0;
    else        req1_v[i] = 1'b0;
    rem[i][p] = 0;
  endtask

  task automatic rand_req(input int i, input int p);
    logic [7:0] a;
    a = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 31));
    new_req(i, p, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)), 1);
  endtask

  function automatic bit ack_of(input int i, input int p);
    return (p == 0) ? ack0_v[i] : ack1_v[i];
  endfunction

  function automatic bit in_flight(input int i, input int p);
    int d;
    d = edge_n - g_edge[i];
    return (d >= 0) && (d <= wc_of(i)) && (int'(g_port[i]) == p);
  endfunction

  function automatic bit any_pending();
    for (int i = 0; i < NI; i++)
      if (rem[i][0] > 0 || rem[i][1] > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_acks();
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++)
        if (ack_of(i, p) && rem[i][p] > 0) begin
          rem[i][p]--;
          if (rem[i][p] == 0) drop_req(i, p);
        end
  endtask

  task automatic service(input int max_t, input string nm);
    int t;
    t = 0;
    while (any_pending() && t < max_t) begin
      tick();
      drive_acks();
      t++;
    end
    chk(nm, 0, int'(any_pending()), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    int base;
    for (int i = 0; i < NI; i++) begin
      req0_v[i] = 0; we0_v[i] = 0; addr0_v[i] = 0; wdata0_v[i] = 0;
      req1_v[i] = 0; we1_v[i] = 0; addr1_v[i] = 0; wdata1_v[i] = 0;
      rem[i][0] = 0; rem[i][1] = 0;
    end
    clear_stats();
    rst = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk("rst_busy",   i, int'(busy_v[i]),    0);
      chk("rst_ena",    i, int'(mem_ena_v[i]), 0);
      chk("rst_rdata0", i, int'(rdata0_v[i]),  0);
      chk("rst_rdata1", i, int'(rdata1_v[i]),  0);
      chk("rst_state",  i, int'(dbg_v[i]),     int'(ST_IDLE));
    end
    rst = 1'b0;
    tick();

    // CPU read of 0x10 holding 0x5A
    clear_stats();
    base = tick_n;
    for (int i = 0; i < NI; i++) new_req(i, 0, 1'b0, 8'h10, 8'h00, 1);
    service(40, "t1_timeout");
    repeat (3) tick();
    chk("t1_ack_latency_w2", 0, ack_at[0][0] - base, 3);
    chk("t1_read_width_w2",  0, rd_cnt[0], 2);
    for (int i = 0; i < NI; i++) begin
      chk("t1_read_width", i, rd_cnt[i], wc_of(i));
      chk("t1_ack_latency", i, ack_at[i][0] - base, wc_of(i) + 1);
      chk("t1_rdata0", i, int'(rdata0_v[i]), 8'h5A);
      chk("t1_ack_count", i, ack_n[i], 1);
      chk("t1_ack_port", i, int'(ack_port[i][0]), 0);
    end

    // loader write 0xC3 to 0x20
    clear_stats();
    for (int i = 0; i < NI; i++) new_req(i, 1, 1'b1, 8'h20, 8'hC3, 1);
    service(40, "t2_timeout");
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk("t2_write_width", i, wr_cnt[i], wc_of(i));
      chk("t2_read_none", i, rd_cnt[i], 0);
      chk("t2_addr", i, int'(wr_addr_seen[i]), 8'h20);
      chk("t2_wdata", i, int'(wr_data_seen[i]), 8'hC3);
      chk("t2_ack_count", i, ack_n[i], 1);
      chk("t2_ack_port", i, int'(ack_port[i][0]), 1);
      chk("t2_rdata1", i, int'(rdata1_v[i]), 8'h00);
      chk("t2_rdata0_kept", i, int'(rdata0_v[i]), 8'h5A);
    end

    // both ports held from reset for four accesses
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    clear_stats();
    for (int i = 0; i < NI; i++) begin
      new_req(i, 0, 1'b0, 8'h30, 8'h00, 2);
      new_req(i, 1, 1'b1, 8'h31, 8'h77, 2);
    end
    service(150, "t3_timeout");
    repeat (3) tick();
    chk("t3_gap_w2", 0, ack_at[0][1] - ack_at[0][0], 4);
    for (int i = 0; i < NI; i++) begin
      chk("t3_ack_count", i, ack_n[i], 4);
      for (int k = 0; k < 4; k++) chk("t3_grant_order", i, int'(ack_port[i][k]), k % 2);
      for (int k = 1; k < 4; k++) chk("t3_gap", i, ack_at[i][k] - ack_at[i][k-1], wc_of(i) + 2);
    end

    // request dropped during the first access cycle
    clear_stats();
    for (int i = 0; i < NI; i++) new_req(i, 0, 1'b0, 8'h10, 8'h00, 1);
    tick();
    for (int i = 0; i < NI; i++) drop_req(i, 0);
    repeat (24) tick();
    for (int i = 0; i < NI; i++) begin
      chk("t4_ack_count", i, ack_n[i], 1);
      chk("t4_busy_cycles", i, busy_cnt[i], wc_of(i) + 1);
      chk("t4_read_width", i, rd_cnt[i], wc_of(i));
    end

    // reset in the middle of an access
    clear_stats();
    for (int i = 0; i < NI; i++) new_req(i, 0, 1'b0, 8'h10, 8'h00, 1);
    tick();
    for (int i = 0; i < NI; i++) chk("t5_pre_ena", i, int'(mem_ena_v[i]), 1);
    #2;
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("t5_ena_async",  i, int'(mem_ena_v[i]),  0);
      chk("t5_read_async", i, int'(mem_read_v[i]), 0);
      chk("t5_busy_async", i, int'(busy_v[i]),     0);
      drop_req(i, 0);
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) chk("t5_no_ack", i, ack_n[i], 0);
    clear_stats();
    for (int i = 0; i < NI; i++) begin
      new_req(i, 0, 1'b0, 8'h40, 8'h00, 1);
      new_req(i, 1, 1'b0, 8'h41, 8'h00, 1);
    end
    service(80, "t5_timeout");
    repeat (3) tick();
    for (int i = 0; i < NI; i++) begin
      chk("t5_first_port",  i, int'(ack_port[i][0]), 0);
      chk("t5_second_port", i, int'(ack_port[i][1]), 1);
    end

    // random traffic
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int i = 0; i < NI; i++)
        for (int p = 0; p < 2; p++) begin
          if (ack_of(i, p)) begin
            if (rem[i][p] > 0) begin
              if ($urandom_range(0, 2) == 0) rand_req(i, p);
              else                           drop_req(i, p);
            end
          end else if (rem[i][p] == 0 && !in_flight(i, p)) begin
            if ($urandom_range(0, 3) == 0) rand_req(i, p);
          end else if (rem[i][p] > 0 && in_flight(i, p) && $urandom_range(0, 15) == 0) begin
            drop_req(i, p);
          end
        end
    end
    service(300, "drain_timeout");
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
